// File: rtl/service_protocol_encoder.sv
// service_protocol_encoder
//   Builds one service-protocol packet for the SPI transmitter.
//   Word order: {addr,8'h00}, {size,cmd}, payload[0..size-1], sum16, TAIL_WORD.
//   The sum is a 16-bit wrapping add over the header, size/cmd and payload words.
//
// Ports
//   clk, rst                 single clock, synchronous active-high reset
//   start, addr, cmd_code,   packet request; fields latched when accepted in IDLE
//   size
//   in_data/in_valid/in_ready    payload source handshake
//   out_data/out_request/out_done  word push to the transmitter (request held until done)
//   busy                     packet in progress
//   pkt_done / pkt_err       one-cycle pulses: packet complete / payload timeout abort
module service_protocol_encoder #(
    parameter logic [15:0] TAIL_WORD  = 16'h0000,
    parameter int          IN_TIMEOUT = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  addr,
    input  logic [7:0]  cmd_code,
    input  logic [7:0]  size,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] out_data,
    output logic        out_request,
    input  logic        out_done,
    output logic        busy,
    output logic        pkt_done,
    output logic        pkt_err
);

    localparam int TW = (IN_TIMEOUT > 1) ? $clog2(IN_TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_SZCMD,
        ST_DATA,
        ST_CSUM,
        ST_TAIL
    } state_t;

    state_t        state_reg;
    logic [7:0]    addr_reg;
    logic [7:0]    cmd_reg;
    logic [7:0]    size_reg;
    logic [7:0]    count_reg;
    logic [15:0]   sum_reg;
    logic [TW-1:0] tmo_reg;
    logic [15:0]   out_data_reg;
    logic          out_request_reg;
    logic          pkt_done_reg;
    logic          pkt_err_reg;

    // Payload is only accepted while no word is waiting on the sink.
    assign in_ready    = (state_reg == ST_DATA) && !out_request_reg && (count_reg < size_reg);
    assign busy        = (state_reg != ST_IDLE);
    assign out_data    = out_data_reg;
    assign out_request = out_request_reg;
    assign pkt_done    = pkt_done_reg;
    assign pkt_err     = pkt_err_reg;

    // Every output state works the same way: with out_request low the word is
    // loaded and request raised; with request high, out_done drops it and moves
    // on. The next state therefore always sees request low for one cycle first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            addr_reg        <= '0;
            cmd_reg         <= '0;
            size_reg        <= '0;
            count_reg       <= '0;
            sum_reg         <= '0;
            tmo_reg         <= '0;
            out_data_reg    <= '0;
            out_request_reg <= 1'b0;
            pkt_done_reg    <= 1'b0;
            pkt_err_reg     <= 1'b0;
        end else begin
            pkt_done_reg <= 1'b0;
            pkt_err_reg  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        addr_reg  <= addr;
                        cmd_reg   <= cmd_code;
                        size_reg  <= size;
                        count_reg <= '0;
                        sum_reg   <= '0;
                        tmo_reg   <= '0;
                        state_reg <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (!out_request_reg) begin
                        out_data_reg    <= {addr_reg, 8'h00};
                        sum_reg         <= sum_reg + {addr_reg, 8'h00};
                        out_request_reg <= 1'b1;
                    end else if (out_done) begin
                        out_request_reg <= 1'b0;
                        state_reg       <= ST_SZCMD;
                    end
                end
                ST_SZCMD: begin
                    if (!out_request_reg) begin
                        out_data_reg    <= {size_reg, cmd_reg};
                        sum_reg         <= sum_reg + {size_reg, cmd_reg};
                        out_request_reg <= 1'b1;
                    end else if (out_done) begin
                        out_request_reg <= 1'b0;
                        state_reg       <= (size_reg == 8'd0) ? ST_CSUM : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (!out_request_reg) begin
                        // count < size always holds here; DATA is left as soon as they meet
                        if (in_valid) begin
                            out_data_reg    <= in_data;
                            sum_reg         <= sum_reg + in_data;
                            out_request_reg <= 1'b1;
                            tmo_reg         <= '0;
                        end else if (tmo_reg == TW'(IN_TIMEOUT - 1)) begin
                            pkt_err_reg <= 1'b1;
                            tmo_reg     <= '0;
                            state_reg   <= ST_IDLE;
                        end else begin
                            tmo_reg <= tmo_reg + 1'b1;
                        end
                    end else if (out_done) begin
                        out_request_reg <= 1'b0;
                        count_reg       <= count_reg + 8'd1;
                        if (count_reg + 8'd1 == size_reg) begin
                            state_reg <= ST_CSUM;
                        end
                    end
                end
                ST_CSUM: begin
                    if (!out_request_reg) begin
                        out_data_reg    <= sum_reg;
                        out_request_reg <= 1'b1;
                    end else if (out_done) begin
                        out_request_reg <= 1'b0;
                        state_reg       <= ST_TAIL;
                    end
                end
                ST_TAIL: begin
                    if (!out_request_reg) begin
                        out_data_reg    <= TAIL_WORD;
                        out_request_reg <= 1'b1;
                    end else if (out_done) begin
                        out_request_reg <= 1'b0;
                        pkt_done_reg    <= 1'b1;
                        state_reg       <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg       <= ST_IDLE;
                    out_request_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_service_protocol_encoder.sv
// Directed testbench for service_protocol_encoder: drives packets, acts as the
// payload source and the transmitter sink, and compares every pushed word with
// a hand-computed list.
module tb_service_protocol_encoder;

    localparam int TMO    = 20;
    localparam int BUDGET = 3000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  addr;
    logic [7:0]  cmd_code;
    logic [7:0]  size;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_request;
    logic        out_done;
    logic        busy;
    logic        pkt_done;
    logic        pkt_err;

    service_protocol_encoder #(
        .TAIL_WORD (16'h0000),
        .IN_TIMEOUT(TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .addr       (addr),
        .cmd_code   (cmd_code),
        .size       (size),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_request(out_request),
        .out_done   (out_done),
        .busy       (busy),
        .pkt_done   (pkt_done),
        .pkt_err    (pkt_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [15:0] exp_w [8];
    int          n_exp;
    logic [15:0] pay [4];
    int          got_words;
    bit          saw_done, saw_err, saw_ready;
    int          rise_cyc, err_cyc;

    // One packet: start pulse, then per cycle (at negedge) supply payload and
    // acknowledge words after `dly` waiting cycles. abort_k >= 0 asserts rst
    // once that many words are consumed and the next one is on the bus.
    task automatic run_pkt(input logic [7:0] a, input logic [7:0] c, input logic [7:0] s,
                           input int dly, input int n_sup, input int abort_k, input bit poke);
        int k = 0;
        int sup = 0;
        int wait_cnt = 0;
        int cyc = 0;
        bit prev_rdy = 1'b0;
        saw_done  = 1'b0;
        saw_err   = 1'b0;
        saw_ready = 1'b0;
        rise_cyc  = -1;
        err_cyc   = -1;
        @(negedge clk);
        addr = a; cmd_code = c; size = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("lat_req_low", 32'(out_request), 32'd0);
        check("busy_after_start", 32'(busy), 32'd1);
        @(negedge clk);
        check("lat_req_high", 32'(out_request), 32'd1);
        while (cyc < BUDGET) begin
            start = 1'b0; out_done = 1'b0; in_valid = 1'b0;
            if (pkt_done) saw_done = 1'b1;
            if (pkt_err) begin saw_err = 1'b1; err_cyc = cyc; end
            if (saw_done || saw_err) break;
            if (in_ready) begin
                saw_ready = 1'b1;
                if (!prev_rdy) rise_cyc = cyc;
            end
            prev_rdy = in_ready;
            if (in_ready && sup < n_sup) begin
                in_valid = 1'b1; in_data = pay[sup]; sup++;
            end
            if (abort_k >= 0 && k == abort_k && out_request) begin
                rst = 1'b1;
                break;
            end
            if (poke && k == 3 && out_request && wait_cnt == 0) begin
                start = 1'b1; addr = 8'h55; cmd_code = 8'h66; size = 8'h09;
            end
            if (out_request) begin
                if (k < n_exp) check($sformatf("word%0d", k), 32'(out_data), 32'(exp_w[k]));
                else           check("extra_word", 32'(k), 32'(n_exp));
                if (wait_cnt == dly) begin
                    out_done = 1'b1; k++; wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        got_words = k;
        start = 1'b0; out_done = 1'b0; in_valid = 1'b0;
        if (cyc >= BUDGET) check("cycle_budget", 32'd0, 32'd1);
        $display("pkt addr=%h cmd=%h size=%0d words=%0d done=%0b err=%0b",
                 a, c, s, got_words, saw_done, saw_err);
    endtask

    task automatic check_idle_after(input string tag);
        @(negedge clk);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_pulse"}, 32'(pkt_done | pkt_err), 32'd0);
    endtask

    task automatic load_case1;
        pay[0] = 16'hEFAB; pay[1] = 16'h0001;
        exp_w[0] = 16'hAB00; exp_w[1] = 16'h02A2; exp_w[2] = 16'hEFAB;
        exp_w[3] = 16'h0001; exp_w[4] = 16'h9D4E; exp_w[5] = 16'h0000;
        n_exp = 6;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; addr = '0; cmd_code = '0; size = '0;
        in_data = '0; in_valid = 1'b0; out_done = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_request", 32'(out_request), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_pkt_done", 32'(pkt_done), 32'd0);
        check("rst_pkt_err", 32'(pkt_err), 32'd0);
        rst = 1'b0;

        // Case 1: basic two-word payload
        load_case1();
        run_pkt(8'hAB, 8'hA2, 8'd2, 1, 2, -1, 1'b0);
        check("c1_done", 32'(saw_done), 32'd1);
        check("c1_words", 32'(got_words), 32'd6);
        check_idle_after("c1");

        // Case 2: empty payload
        exp_w[0] = 16'h0100; exp_w[1] = 16'h0010; exp_w[2] = 16'h0110; exp_w[3] = 16'h0000;
        n_exp = 4;
        run_pkt(8'h01, 8'h10, 8'd0, 1, 0, -1, 1'b0);
        check("c2_done", 32'(saw_done), 32'd1);
        check("c2_words", 32'(got_words), 32'd4);
        check("c2_no_ready", 32'(saw_ready), 32'd0);
        check_idle_after("c2");

        // Case 3: checksum wrap
        pay[0] = 16'hFFFF;
        exp_w[0] = 16'hFF00; exp_w[1] = 16'h01FF; exp_w[2] = 16'hFFFF;
        exp_w[3] = 16'h00FE; exp_w[4] = 16'h0000;
        n_exp = 5;
        run_pkt(8'hFF, 8'hFF, 8'd1, 0, 1, -1, 1'b0);
        check("c3_done", 32'(saw_done), 32'd1);
        check("c3_words", 32'(got_words), 32'd5);
        check_idle_after("c3");

        // Case 4: slow sink, plus a start pulse mid-packet that must be ignored
        load_case1();
        run_pkt(8'hAB, 8'hA2, 8'd2, 7, 2, -1, 1'b1);
        check("c4_done", 32'(saw_done), 32'd1);
        check("c4_words", 32'(got_words), 32'd6);
        check_idle_after("c4");

        // Case 5: payload starvation timeout
        pay[0] = 16'h1234;
        exp_w[0] = 16'h1200; exp_w[1] = 16'h0334; exp_w[2] = 16'h1234;
        n_exp = 3;
        run_pkt(8'h12, 8'h34, 8'd3, 1, 1, -1, 1'b0);
        check("c5_err", 32'(saw_err), 32'd1);
        check("c5_no_done", 32'(saw_done), 32'd0);
        check("c5_words", 32'(got_words), 32'd3);
        check("c5_tmo_cycles", 32'(err_cyc - rise_cyc), 32'(TMO));
        check("c5_busy_at_err", 32'(busy), 32'd0);
        check_idle_after("c5");

        // Case 6: reset during DATA, then a full packet
        load_case1();
        run_pkt(8'hAB, 8'hA2, 8'd2, 1, 2, 2, 1'b0);
        @(negedge clk);
        check("c6_rst_out_request", 32'(out_request), 32'd0);
        check("c6_rst_out_data", 32'(out_data), 32'd0);
        check("c6_rst_busy", 32'(busy), 32'd0);
        check("c6_rst_in_ready", 32'(in_ready), 32'd0);
        check("c6_rst_pulses", 32'(pkt_done | pkt_err), 32'd0);
        rst = 1'b0;
        run_pkt(8'hAB, 8'hA2, 8'd2, 1, 2, -1, 1'b0);
        check("c6_done", 32'(saw_done), 32'd1);
        check("c6_words", 32'(got_words), 32'd6);
        check_idle_after("c6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
